// File: rtl/mix_columns_engine.sv
// ---------------------------------------------------------------------------
// mix_columns_engine
//
// Purpose:
//   AES MixColumns / InvMixColumns unit with valid/ready handshakes on both
//   sides. It transforms COLS_PER_CYCLE 32-bit columns per cycle, so a block
//   takes BEATS = 4/COLS_PER_CYCLE processing cycles. Each block can be run
//   forward, inverse, or bypassed unchanged. Bypass is used for the final
//   round and has the same latency as the other modes.
//
// Parameters:
//   COLS_PER_CYCLE  columns transformed per cycle (1, 2 or 4)
//
// Ports:
//   clk       in   1    rising-edge clock
//   rst       in   1    asynchronous reset, active-high
//   valid_i   in   1    input block valid
//   ready_o   out  1    engine accepts a block this cycle
//   inv_i     in   1    1 = InvMixColumns, 0 = MixColumns (sampled on accept)
//   bypass_i  in   1    1 = pass through unchanged (sampled on accept, wins over inv_i)
//   state_i   in   128  input state, column c = [127-32c -: 32], row r byte at [.. -8r -: 8]
//   valid_o   out  1    output block valid
//   ready_i   in   1    downstream accepts the output
//   state_o   out  128  result state, same byte order as state_i
// ---------------------------------------------------------------------------
module mix_columns_engine #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic         inv_i,
  input  logic         bypass_i,
  input  logic [127:0] state_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [127:0] state_o
);

  localparam int         BEATS     = 4 / COLS_PER_CYCLE;
  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_param
    $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t       r_state;
  logic [127:0] r_work;
  logic [127:0] r_out;
  logic         r_valid;
  logic         r_inv;
  logic         r_bypass;
  logic [1:0]   r_cnt;

  // Multiplication by 2 in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One column through the forward or inverse matrix. The inverse
  // coefficients come from the x2/x4/x8 chain:
  // 09 = 8+1, 0b = 8+2+1, 0d = 8+4+1, 0e = 8+4+2.
  function automatic logic [31:0] mixColumn(input logic [31:0] col, input logic inv);
    logic [7:0]  a  [4];
    logic [7:0]  x2 [4];
    logic [7:0]  x4 [4];
    logic [7:0]  x8 [4];
    logic [7:0]  m1, m2, m3;
    logic [31:0] res;
    res = '0;
    for (int r = 0; r < 4; r++) begin
      a[r]  = col[31-8*r -: 8];
      x2[r] = xtime(a[r]);
      x4[r] = xtime(x2[r]);
      x8[r] = xtime(x4[r]);
    end
    for (int r = 0; r < 4; r++) begin
      m1 = 8'h00;
      m2 = 8'h00;
      m3 = 8'h00;
      if (inv) begin
        m1 = x8[(r+1)%4] ^ x2[(r+1)%4] ^ a[(r+1)%4];
        m2 = x8[(r+2)%4] ^ x4[(r+2)%4] ^ a[(r+2)%4];
        m3 = x8[(r+3)%4] ^ a[(r+3)%4];
        res[31-8*r -: 8] = (x8[r] ^ x4[r] ^ x2[r]) ^ m1 ^ m2 ^ m3;
      end else begin
        m1 = x2[(r+1)%4] ^ a[(r+1)%4];
        res[31-8*r -: 8] = x2[r] ^ m1 ^ a[(r+2)%4] ^ a[(r+3)%4];
      end
    end
    return res;
  endfunction

  logic [31:0]  w_cols      [4];
  logic [31:0]  w_next_cols [4];
  logic [31:0]  w_mix       [COLS_PER_CYCLE];
  logic [127:0] w_next_work;

  for (genvar c = 0; c < 4; c++) begin : g_unpack
    assign w_cols[c]                   = r_work[127-32*c -: 32];
    assign w_next_work[127-32*c -: 32] = w_next_cols[c];
  end

  // Only COLS_PER_CYCLE mixers exist. Each lane picks its column out of the
  // current group, so a smaller COLS_PER_CYCLE gives a smaller datapath.
  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_lane
    logic [1:0] w_idx;
    assign w_idx    = 2'(32'(r_cnt) * 32'(COLS_PER_CYCLE) + 32'(k));
    assign w_mix[k] = r_bypass ? w_cols[w_idx] : mixColumn(w_cols[w_idx], r_inv);
  end

  // Each column is written back only during its own beat.
  // At all other times it keeps its current value.
  for (genvar c = 0; c < 4; c++) begin : g_wb
    localparam logic [1:0] GRP  = 2'(c / COLS_PER_CYCLE);
    localparam int         SLOT = c % COLS_PER_CYCLE;
    assign w_next_cols[c] = (r_cnt == GRP) ? w_mix[SLOT] : w_cols[c];
  end

  // In DONE, ready_o follows ready_i. This lets a new block be taken on the
  // same edge that hands off the current result.
  assign ready_o = !rst && ((r_state == IDLE) || ((r_state == DONE) && ready_i));
  assign valid_o = r_valid;
  assign state_o = r_out;

  // Handshake FSM and in-place column processing. r_out is loaded only when
  // a block completes. It therefore keeps the last result while the next
  // block is being worked on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_work   <= '0;
      r_out    <= '0;
      r_valid  <= 1'b0;
      r_inv    <= 1'b0;
      r_bypass <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (valid_i) begin
            r_work   <= state_i;
            r_inv    <= inv_i;
            r_bypass <= bypass_i;
            r_cnt    <= '0;
            r_state  <= BUSY;
          end
        end
        BUSY: begin
          r_work <= w_next_work;
          r_cnt  <= r_cnt + 2'd1;
          if (r_cnt == LAST_BEAT) begin
            r_out   <= w_next_work;
            r_valid <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          if (ready_i) begin
            r_valid <= 1'b0;
            if (valid_i) begin
              r_work   <= state_i;
              r_inv    <= inv_i;
              r_bypass <= bypass_i;
              r_cnt    <= '0;
              r_state  <= BUSY;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mix_columns_engine.sv
// ---------------------------------------------------------------------------
// tb_mix_columns_engine
//
// Purpose:
//   Self-checking bench for mix_columns_engine. It builds three engines,
//   with COLS_PER_CYCLE = 1, 2 and 4, and drives them all from the same
//   inputs. Expected results come from a GF(2^8) shift-and-add matrix model.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_mix_columns_engine;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_i;
  logic         inv_i;
  logic         bypass_i;
  logic         ready_i;
  logic [127:0] state_i;

  logic [2:0]   w_ready;
  logic [2:0]   w_valid;
  logic [127:0] w_state [3];

  int cpcOf   [3] = '{1, 2, 4};
  int beatsOf [3] = '{4, 2, 1};

  int nChecks = 0;
  int nFail   = 0;

  typedef struct packed {
    logic [127:0] st;
    logic         inv;
    logic         byp;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [4];

  always #5 clk = ~clk;

  mix_columns_engine #(.COLS_PER_CYCLE(1)) u_c1 (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(w_ready[0]), .inv_i(inv_i),
    .bypass_i(bypass_i), .state_i(state_i), .valid_o(w_valid[0]), .ready_i(ready_i),
    .state_o(w_state[0])
  );

  mix_columns_engine #(.COLS_PER_CYCLE(2)) u_c2 (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(w_ready[1]), .inv_i(inv_i),
    .bypass_i(bypass_i), .state_i(state_i), .valid_o(w_valid[1]), .ready_i(ready_i),
    .state_o(w_state[1])
  );

  mix_columns_engine #(.COLS_PER_CYCLE(4)) u_c4 (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(w_ready[2]), .inv_i(inv_i),
    .bypass_i(bypass_i), .state_i(state_i), .valid_o(w_valid[2]), .ready_i(ready_i),
    .state_o(w_state[2])
  );

  // General GF(2^8) product by shift-and-add, reduced by 0x11b.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  // Circulant-matrix model. For output row r, input row j uses
  // base[(j - r) mod 4] as its coefficient.
  function automatic logic [127:0] refMix(input logic [127:0] s, input logic inv, input logic byp);
    logic [31:0]  base;
    logic [127:0] o;
    logic [7:0]   acc;
    int           k;
    base = inv ? 32'h0e0b0d09 : 32'h02030101;
    o    = s;
    if (!byp) begin
      for (int c = 0; c < 4; c++) begin
        for (int r = 0; r < 4; r++) begin
          acc = 8'h00;
          for (int j = 0; j < 4; j++) begin
            k   = (j - r + 4) % 4;
            acc = acc ^ gmul(base[31-8*k -: 8], s[127-32*c-8*j -: 8]);
          end
          o[127-32*c-8*r -: 8] = acc;
        end
      end
    end
    return o;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic failTimeout(input string name);
    nChecks++;
    nFail++;
    $display("[TB] FAIL %s: got no valid_o, expected a result", name);
  endtask

  // Sends one block to all three engines while they are idle. After the
  // accept, the inputs are scrambled, so a stray reuse of the live inputs
  // shows up. Each engine is then checked for latency and result.
  task automatic applyStimulus(input logic [127:0] st, input logic inv, input logic byp,
                               input logic [127:0] exp, input string name);
    bit seen [3];
    for (int i = 0; i < 3; i++) seen[i] = 1'b0;
    @(negedge clk);
    valid_i  = 1'b1;
    state_i  = st;
    inv_i    = inv;
    bypass_i = byp;
    #1;
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("%s.ready.cpc%0d", name, cpcOf[i]), 128'(w_ready[i]), 128'(1));
    @(posedge clk);
    #1;
    valid_i  = 1'b0;
    state_i  = {$urandom, $urandom, $urandom, $urandom};
    inv_i    = ~inv;
    bypass_i = ~byp;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (w_valid[i] && !seen[i]) begin
          seen[i] = 1'b1;
          checkOutput($sformatf("%s.lat.cpc%0d", name, cpcOf[i]), 128'(cyc - 1), 128'(beatsOf[i]));
          checkOutput($sformatf("%s.data.cpc%0d", name, cpcOf[i]), w_state[i], exp);
        end
      end
    end
    for (int i = 0; i < 3; i++)
      if (!seen[i]) failTimeout($sformatf("%s.timeout.cpc%0d", name, cpcOf[i]));
  endtask

  initial begin
    logic [127:0] expQ [$];
    logic [127:0] expA;
    logic [127:0] st;
    logic         inv;
    logic         byp;
    logic         take;
    int           accepts;
    int           outs;
    int           lastAcc;
    int           cyc;
    int           wait_n;
    bit           sawValid;

    vecs[0] = '{128'hdb135345_f20a225c_01010101_d4d4d4d5, 1'b0, 1'b0,
                128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6};
    vecs[1] = '{128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6, 1'b1, 1'b0,
                128'hdb135345_f20a225c_01010101_d4d4d4d5};
    vecs[2] = '{128'h00112233_44556677_8899aabb_ccddeeff, 1'b1, 1'b1,
                128'h00112233_44556677_8899aabb_ccddeeff};
    vecs[3] = '{128'hc6c6c6c6_d4d4d4d5_2d26314c_01010101, 1'b0, 1'b0,
                128'hc6c6c6c6_d5d5d7d6_4d7ebdf8_01010101};

    // Reset state.
    rst      = 1'b1;
    valid_i  = 1'b0;
    inv_i    = 1'b0;
    bypass_i = 1'b0;
    ready_i  = 1'b1;
    state_i  = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("rst.ready.cpc%0d", cpcOf[i]), 128'(w_ready[i]), 128'(0));
      checkOutput($sformatf("rst.valid.cpc%0d", cpcOf[i]), 128'(w_valid[i]), 128'(0));
      checkOutput($sformatf("rst.state.cpc%0d", cpcOf[i]), w_state[i], 128'(0));
    end
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("idle.ready.cpc%0d", cpcOf[i]), 128'(w_ready[i]), 128'(1));

    // Known-answer table.
    for (int v = 0; v < 4; v++)
      applyStimulus(vecs[v].st, vecs[v].inv, vecs[v].byp, vecs[v].exp, $sformatf("vec%0d", v));

    // Random single blocks, with all modes.
    for (int n = 0; n < 6; n++) begin
      st  = {$urandom, $urandom, $urandom, $urandom};
      inv = 1'($urandom_range(0, 1));
      byp = ($urandom_range(0, 3) == 0);
      applyStimulus(st, inv, byp, refMix(st, inv, byp), $sformatf("rand%0d", n));
    end

    // Backpressure. The result must be held in DONE for 5 cycles. A new
    // block must then be accepted on the same edge that releases it.
    $display("[TB] backpressure sequence");
    ready_i = 1'b0;
    @(negedge clk);
    st       = {$urandom, $urandom, $urandom, $urandom};
    expA     = refMix(st, 1'b0, 1'b0);
    valid_i  = 1'b1;
    state_i  = st;
    inv_i    = 1'b0;
    bypass_i = 1'b0;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    wait_n  = 0;
    while (!w_valid[0] && wait_n < 10) begin
      @(negedge clk);
      wait_n++;
    end
    if (!w_valid[0]) failTimeout("bp.first");
    for (int n = 0; n < 5; n++) begin
      checkOutput($sformatf("bp.valid%0d", n), 128'(w_valid[0]), 128'(1));
      checkOutput($sformatf("bp.state%0d", n), w_state[0], expA);
      checkOutput($sformatf("bp.ready%0d", n), 128'(w_ready[0]), 128'(0));
      @(negedge clk);
    end
    ready_i = 1'b1;
    valid_i = 1'b1;
    state_i = expA;
    inv_i   = 1'b1;
    #1;
    checkOutput("bp.release.ready", 128'(w_ready[0]), 128'(1));
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    checkOutput("bp.accepted.valid", 128'(w_valid[0]), 128'(0));
    checkOutput("bp.accepted.hold", w_state[0], expA);
    wait_n = 0;
    while (!w_valid[0] && wait_n < 10) begin
      @(negedge clk);
      wait_n++;
    end
    if (!w_valid[0]) failTimeout("bp.second");
    else checkOutput("bp.second.data", w_state[0], st);
    repeat (8) @(negedge clk);

    // Streaming. valid_i is held high and ready_i=1; results come out in order.
    $display("[TB] streaming sequence");
    accepts  = 0;
    outs     = 0;
    lastAcc  = 0;
    cyc      = 0;
    state_i  = {$urandom, $urandom, $urandom, $urandom};
    inv_i    = 1'($urandom_range(0, 1));
    bypass_i = 1'b0;
    valid_i  = 1'b1;
    while (outs < 9 && cyc < 300) begin
      #1;
      if (w_valid[0]) begin
        if (expQ.size() == 0) begin
          failTimeout("stream.unexpected");
        end else begin
          checkOutput($sformatf("stream.out%0d", outs), w_state[0], expQ.pop_front());
        end
        outs++;
      end
      take = w_ready[0] && valid_i;
      if (take) begin
        expQ.push_back(refMix(state_i, inv_i, 1'b0));
        accepts++;
        if (accepts > 1)
          checkOutput($sformatf("stream.spacing%0d", accepts), 128'(cyc - lastAcc), 128'(beatsOf[0] + 1));
        lastAcc = cyc;
      end
      @(posedge clk);
      #1;
      if (take) begin
        if (accepts == 9) begin
          valid_i = 1'b0;
        end else begin
          state_i = {$urandom, $urandom, $urandom, $urandom};
          inv_i   = 1'($urandom_range(0, 1));
        end
      end
      @(negedge clk);
      cyc++;
    end
    valid_i = 1'b0;
    if (outs < 9) failTimeout("stream.timeout");
    repeat (8) @(negedge clk);

    // Reset during beat 2 of a block: no output may follow.
    $display("[TB] reset mid-block sequence");
    @(negedge clk);
    valid_i  = 1'b1;
    state_i  = {$urandom, $urandom, $urandom, $urandom};
    inv_i    = 1'b0;
    bypass_i = 1'b0;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("midrst.valid.cpc%0d", cpcOf[i]), 128'(w_valid[i]), 128'(0));
      checkOutput($sformatf("midrst.state.cpc%0d", cpcOf[i]), w_state[i], 128'(0));
      checkOutput($sformatf("midrst.ready.cpc%0d", cpcOf[i]), 128'(w_ready[i]), 128'(0));
    end
    @(negedge clk);
    rst      = 1'b0;
    sawValid = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (w_valid != 3'b000) sawValid = 1'b1;
    end
    checkOutput("midrst.no_output", 128'(sawValid), 128'(0));
    st = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(st, 1'b1, 1'b0, refMix(st, 1'b1, 1'b0), "postrst");

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
    $finish;
  end

endmodule
